mips_trace_tx: RTL and testbench

MIPS_TRACE_TX -- requirements
Module: mips_trace_tx

---
 rtl/mips_trace_pkg.sv | 48 ++++
 rtl/trace_fifo.sv | 51 +++++
 rtl/mips_trace_tx.sv | 186 ++++++++++++++++++
 tb/tb_mips_trace_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
`default_nettype none
// ============================================================================
// mips_trace_pkg : shared types and constants for the MIPS retirement trace
//                  serializer. Optional macro: MIPS_TRACE_CHECKSUM_EN.
// Revision       : 1.0 - initial release
// ============================================================================
package mips_trace_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bit positions within the FLAGS byte
    localparam int FLAG_WE  = 0;
    localparam int FLAG_OVF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        PC    = 3'd2,
        INSTR = 3'd3,
        FLAGS = 3'd4,
        ADDR  = 3'd5,
`ifdef MIPS_TRACE_CHECKSUM_EN
        WDATA = 3'd6,
        CSUM  = 3'd7
`else
        WDATA = 3'd6
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wd;
    } trace_rec_t;

    function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo : record FIFO with combinational head read; full is a pure
//              function of stored occupancy so it ignores a same-edge pop.
// Revision   : 1.0 - initial release
// ============================================================================
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  trace_rec_t                 wdata,
    input  logic                       pop,
    output trace_rec_t                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/mips_trace_tx.sv
`default_nettype none
// ============================================================================
// mips_trace_tx : serializes retired-instruction records into a byte stream.
//                 Optional macro MIPS_TRACE_CHECKSUM_EN appends an XOR byte.
// Revision      : 1.0 - initial release
// ============================================================================
module mips_trace_tx
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  drop_cnt,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    trace_rec_t      in_rec;
    trace_rec_t      head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            drop;
    logic            xfer;
    logic            ovf;
    logic            body_done;
    logic            rec_done;
    logic [7:0]      flags;
    state_t          state;
    state_t          state_nx;
    logic [1:0]      bcnt;
    logic [1:0]      bcnt_nx;

    assign in_rec   = '{pc, instr, mem_we, mem_addr, mem_wd};
    assign push     = trace_valid && !full;
    assign drop     = trace_valid && full;
    assign tx_valid = (state != IDLE);
    assign xfer     = tx_valid && tx_ready;
    assign busy     = !empty || tx_valid;

    // The record being sent stays at the FIFO head until its last byte goes
    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        flags           = 8'h00;
        flags[FLAG_OVF] = ovf;
        flags[FLAG_WE]  = head.mem_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bcnt     <= 2'd0;
            ovf      <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (xfer && state == FLAGS) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef MIPS_TRACE_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= 8'h00;
        else if (xfer)
            csum <= (state == HDR) ? SYNC_BYTE : (csum ^ tx_data);
    end
`endif

    always_comb begin
        state_nx  = state;
        bcnt_nx   = bcnt;
        tx_data   = 8'h00;
        body_done = 1'b0;
        rec_done  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                bcnt_nx = 2'd0;
                if (!empty)
                    state_nx = HDR;
            end
            HDR: begin
                tx_data = SYNC_BYTE;
                if (xfer)
                    state_nx = PC;
            end
            PC: begin
                tx_data = msb_byte(head.pc, bcnt);
                if (xfer) begin
                    bcnt_nx = bcnt + 2'd1;
                    if (bcnt == 2'd3)
                        state_nx = INSTR;
                end
            end
            INSTR: begin
                tx_data = msb_byte(head.instr, bcnt);
                if (xfer) begin
                    bcnt_nx = bcnt + 2'd1;
                    if (bcnt == 2'd3)
                        state_nx = FLAGS;
                end
            end
            FLAGS: begin
                tx_data = flags;
                if (xfer) begin
                    if (head.mem_we)
                        state_nx = ADDR;
                    else
                        body_done = 1'b1;
                end
            end
            ADDR: begin
                tx_data = msb_byte(head.mem_addr, bcnt);
                if (xfer) begin
                    bcnt_nx = bcnt + 2'd1;
                    if (bcnt == 2'd3)
                        state_nx = WDATA;
                end
            end
            WDATA: begin
                tx_data = msb_byte(head.mem_wd, bcnt);
                if (xfer) begin
                    bcnt_nx = bcnt + 2'd1;
                    if (bcnt == 2'd3)
                        body_done = 1'b1;
                end
            end
`ifdef MIPS_TRACE_CHECKSUM_EN
            CSUM: begin
                tx_data = csum;
                if (xfer)
                    rec_done = 1'b1;
            end
`endif
            default: state_nx = IDLE;
        endcase

`ifdef MIPS_TRACE_CHECKSUM_EN
        if (body_done)
            state_nx = CSUM;
`else
        rec_done = body_done;
`endif

        // Another record behind the head means the next header follows directly
        if (rec_done) begin
            pop      = 1'b1;
            state_nx = (count > CW'(1)) ? HDR : IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_tx.sv
`default_nettype none
// ============================================================================
// tb_mips_trace_tx : directed scoreboard bench for mips_trace_tx.
// Revision         : 1.0 - initial release
// ============================================================================
module tb_mips_trace_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wd = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  drop_cnt;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    mips_trace_tx #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trace_valid (trace_valid),
        .pc          (pc),
        .instr       (instr),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_rec(input logic [31:0] p, input logic [31:0] i, input logic we,
                           input logic [31:0] a, input logic [31:0] d, input logic ovf);
        logic [7:0] b [$];
        logic [7:0] x;
        b.push_back(8'hA5);
        for (int k = 0; k < 4; k++) b.push_back(8'(p >> (24 - 8*k)));
        for (int k = 0; k < 4; k++) b.push_back(8'(i >> (24 - 8*k)));
        b.push_back({6'b0, ovf, we});
        if (we) begin
            for (int k = 0; k < 4; k++) b.push_back(8'(a >> (24 - 8*k)));
            for (int k = 0; k < 4; k++) b.push_back(8'(d >> (24 - 8*k)));
        end
`ifdef MIPS_TRACE_CHECKSUM_EN
        x = 8'h00;
        foreach (b[k]) x ^= b[k];
        b.push_back(x);
`endif
        foreach (b[k]) exp_q.push_back(b[k]);
    endtask

    task automatic send_rec(input logic [31:0] p, input logic [31:0] i, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
        pc = p; instr = i; mem_we = we; mem_addr = a; mem_wd = d;
        trace_valid = 1'b1;
        @(posedge clk); #2;
        trace_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every valid byte must match the queue head, including stalls
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                chk(tx_ready ? "byte" : "stall_byte", {24'h0, tx_data}, {24'h0, exp_q[0]});
                if (tx_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_tx_data",  {24'h0, tx_data},  32'h00);
        chk("rst_drop_cnt", {24'h0, drop_cnt}, 32'h00);
        chk("rst_busy",     {31'h0, busy},     32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tx_ready = 1'b1;

        // Single load record and first-byte latency
        add_rec(32'h00400000, 32'h8C080004, 1'b0, 32'h0, 32'h0, 1'b0);
        send_rec(32'h00400000, 32'h8C080004, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("latency_idle", {31'h0, tx_valid}, 32'd0);
        chk("latency_busy", {31'h0, busy}, 32'd1);
        @(negedge clk);
        chk("latency_start", {31'h0, tx_valid}, 32'd1);
        @(posedge clk); #2;
        wait_drain(50);
        chk("load_idle_valid", {31'h0, tx_valid}, 32'd0);
        chk("load_idle_busy",  {31'h0, busy}, 32'd0);

        // Store record, sink always ready
        add_rec(32'h00400004, 32'hAC090008, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0);
        send_rec(32'h00400004, 32'hAC090008, 1'b1, 32'h10010008, 32'hDEADBEEF);
        wait_drain(60);
        chk("store_idle_busy", {31'h0, busy}, 32'd0);

        // Same store record with tx_ready toggling every 3 cycles
        tx_ready = 1'b0;
        add_rec(32'h00400004, 32'hAC090008, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0);
        send_rec(32'h00400004, 32'hAC090008, 1'b1, 32'h10010008, 32'hDEADBEEF);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                tx_ready = ((n / 3) % 2) == 1;
                @(posedge clk); #2;
                n++;
            end
        end
        tx_ready = 1'b1;
        chk("stall_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #2;
        chk("stall_idle_busy", {31'h0, busy}, 32'd0);

        // Overflow: 11 records into an 8-deep FIFO with the sink blocked
        tx_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            pc = 32'h00401000 + 32'(4*i); instr = 32'h24000000 + 32'(i);
            mem_we = 1'b0; mem_addr = 32'h0; mem_wd = 32'h0;
            trace_valid = 1'b1;
            if (i < 8) add_rec(pc, instr, 1'b0, 32'h0, 32'h0, i == 0);
            @(posedge clk); #2;
        end
        trace_valid = 1'b0;
        chk("ovf_drop_cnt", {24'h0, drop_cnt}, 32'd3);
        tx_ready = 1'b1;
        wait_drain(400);
        chk("ovf_drop_cnt_hold", {24'h0, drop_cnt}, 32'd3);
        chk("ovf_idle_busy", {31'h0, busy}, 32'd0);

        // Reset in the middle of the INSTR bytes
        add_rec(32'h00400008, 32'hAC0A000C, 1'b1, 32'h10010010, 32'h12345678, 1'b0);
        send_rec(32'h00400008, 32'hAC0A000C, 1'b1, 32'h10010010, 32'h12345678);
        begin
            int n = 0;
            while (exp_q.size() > 12 && n < 50) begin
                @(posedge clk); #2;
                n++;
            end
        end
        chk("mid_reach_instr", 32'(exp_q.size()), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    {31'h0, tx_valid}, 32'd0);
        chk("mid_rst_data",     {24'h0, tx_data}, 32'h00);
        chk("mid_rst_busy",     {31'h0, busy}, 32'd0);
        chk("mid_rst_drop_cnt", {24'h0, drop_cnt}, 32'h00);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_valid", {31'h0, tx_valid}, 32'd0);
        add_rec(32'h0040000C, 32'h8C0B0010, 1'b0, 32'h0, 32'h0, 1'b0);
        send_rec(32'h0040000C, 32'h8C0B0010, 1'b0, 32'h0, 32'h0);
        wait_drain(50);
        chk("post_rst_busy", {31'h0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
